// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-stage FSM states, status codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // The memory stage reports ADR through its dmem_error flag.
  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_t;

  // True when an 8-byte access starting at addr lies fully inside a RAM of size bytes.
  function automatic logic quad_in_range(input logic [63:0] addr, input int unsigned bytes);
    return addr <= 64'(bytes - 8);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide data RAM: one synchronous write port, one asynchronous read port, contents never reset.
module dmem_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-serial 8-byte loads/stores; access requests finish in 9 cycles,
// no-access or bad-address requests in 1; start is dropped unless IDLE.
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    icode,
  input  logic [63:0]                   valE,
  input  logic [63:0]                   valA,
  input  logic [63:0]                   valP,
  input  logic                          ld_en,
  input  logic [$clog2(DMEM_BYTES)-1:0] ld_addr,
  input  logic [7:0]                    ld_data,
  output logic                          busy,
  output logic                          done,
  output logic [63:0]                   valM,
  output logic                          dmem_error
);

  localparam int AW = $clog2(DMEM_BYTES);

  mem_state_t state, state_nxt;

  logic [2:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic          wr_q;
  logic [63:0]   asm_q;

  logic          req_acc;
  logic          req_wr;
  logic [63:0]   req_addr;
  logic [63:0]   req_wdata;
  logic          req_err;
  logic          req_go;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] ram_idx;
  logic [7:0]    ram_rdata;

  always_comb begin
    req_acc   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = valE;
    req_wdata = valA;
    case (icode)
      IRMMOVQ, IPUSHQ: begin
        req_acc = 1'b1;
        req_wr  = 1'b1;
      end
      ICALL: begin
        req_acc   = 1'b1;
        req_wr    = 1'b1;
        req_wdata = valP;
      end
      IMRMOVQ: begin
        req_acc = 1'b1;
      end
      IPOPQ, IRET: begin
        req_acc  = 1'b1;
        req_addr = valA;
      end
      default: begin
        req_acc = 1'b0;
      end
    endcase
    req_err = req_acc && !quad_in_range(req_addr, DMEM_BYTES);
    req_go  = req_acc && !req_err;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = req_go ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (cnt == 3'd7) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      asm_q      <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= 3'd0;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            if (!req_go) begin
              valM       <= '0;
              dmem_error <= req_err;
            end
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            asm_q[8*cnt +: 8] <= ram_rdata;
          end
          if (cnt == 3'd7) begin
            // Top byte comes straight from the RAM so valM is complete on entering DONE.
            valM       <= wr_q ? 64'd0 : {ram_rdata, asm_q[55:0]};
            dmem_error <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // The range check bounds addr_q+7 below DMEM_BYTES, so this sum never wraps.
  assign ram_idx   = addr_q + AW'(cnt);
  assign ram_we    = !rst && (((state == IDLE) && ld_en) || ((state == ACCESS) && wr_q));
  assign ram_waddr = (state == ACCESS) ? ram_idx : ld_addr;
  assign ram_wdata = (state == ACCESS) ? wdata_q[8*cnt +: 8] : ld_data;

  dmem_byte_ram #(
    .DEPTH (DMEM_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_idx),
    .rdata (ram_rdata)
  );

  assign busy = (state == ACCESS);
  assign done = (state == DONE);

endmodule
